// File: rtl/inject_arbiter.sv
// Packet-granular round-robin arbiter sharing one injector stream among NUM_SRC sources.
// The owner keeps the stream until its eop flit is accepted; end-of-applications flags are merged.
module inject_arbiter #(
  parameter int FLIT_SIZE = 32,
  parameter int NUM_SRC   = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_SRC-1:0]           src_tx_i,
  input  logic [NUM_SRC-1:0]           src_eop_i,
  input  logic [NUM_SRC*FLIT_SIZE-1:0] src_data_i,
  output logic [NUM_SRC-1:0]           src_credit_o,
  input  logic [NUM_SRC-1:0]           src_eoa_i,
  output logic                         tx_o,
  output logic [FLIT_SIZE-1:0]         data_o,
  input  logic                         credit_i,
  output logic                         eoa_o,
  output logic [NUM_SRC-1:0]           grant_o
);

  localparam int IDX_W = $clog2(NUM_SRC);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] owner_reg, owner_next;
  logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [15:0]      flit_cnt_reg, flit_cnt_next;
  logic [IDX_W-1:0] pick;
  logic             pick_valid;
  logic             xfer;
  logic             release_pkt;
  logic             owner_tx;
  logic [FLIT_SIZE-1:0] owner_data;

  assign owner_tx   = src_tx_i[owner_reg];
  assign owner_data = src_data_i[int'(owner_reg)*FLIT_SIZE +: FLIT_SIZE];

  // First requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  always_comb begin
    int cand;
    cand       = 0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = int'(rr_ptr_reg) + i;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (!pick_valid && src_tx_i[cand]) begin
        pick       = IDX_W'(cand);
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    rr_ptr_next   = rr_ptr_reg;
    flit_cnt_next = flit_cnt_reg;
    tx_o          = 1'b0;
    data_o        = '0;
    src_credit_o  = '0;
    grant_o       = '0;
    xfer          = 1'b0;
    release_pkt   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          owner_next    = pick;
          flit_cnt_next = '0;
          state_next    = BUSY;
        end
      end
      BUSY: begin
        // Handshake is gated while reset is held so an abandoned packet moves no flit.
        tx_o                    = owner_tx & rst_ni;
        data_o                  = owner_data;
        grant_o[owner_reg]      = 1'b1;
        src_credit_o[owner_reg] = credit_i & rst_ni;
        xfer                    = tx_o & credit_i;
        if (xfer) begin
          if (flit_cnt_reg != 16'hFFFF) flit_cnt_next = flit_cnt_reg + 16'd1;
          if (src_eop_i[owner_reg]) begin
            release_pkt = 1'b1;
            state_next  = IDLE;
            rr_ptr_next = (owner_reg == IDX_W'(NUM_SRC - 1)) ? '0 : owner_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      flit_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      rr_ptr_reg   <= rr_ptr_next;
      flit_cnt_reg <= flit_cnt_next;
      if (release_pkt) assert (flit_cnt_next != 16'd0);
    end
  end

  assign eoa_o = (&src_eoa_i) && (state_reg == IDLE) && !(|src_tx_i);

endmodule

// File: tb/tb_inject_arbiter.sv
// Directed bench for inject_arbiter: a 2-source instance for the packet scenarios and a
// 3-source instance for wrap-around ordering.
module tb_inject_arbiter;

  logic        clk;
  logic        rst_n;

  logic [1:0]  tx_a, eop_a, eoa_a, cred_a, grant_a;
  logic [63:0] data_a;
  logic        txo_a, credit_a, eoao_a;
  logic [31:0] datao_a;

  logic [2:0]  tx_b, eop_b, eoa_b, cred_b, grant_b;
  logic [95:0] data_b;
  logic        txo_b, credit_b, eoao_b;
  logic [31:0] datao_b;

  int total = 0;
  int bad   = 0;

  inject_arbiter #(.FLIT_SIZE(32), .NUM_SRC(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .src_tx_i(tx_a), .src_eop_i(eop_a), .src_data_i(data_a),
    .src_credit_o(cred_a), .src_eoa_i(eoa_a),
    .tx_o(txo_a), .data_o(datao_a), .credit_i(credit_a),
    .eoa_o(eoao_a), .grant_o(grant_a)
  );

  inject_arbiter #(.FLIT_SIZE(32), .NUM_SRC(3)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .src_tx_i(tx_b), .src_eop_i(eop_b), .src_data_i(data_b),
    .src_credit_o(cred_b), .src_eoa_i(eoa_b),
    .tx_o(txo_b), .data_o(datao_b), .credit_i(credit_b),
    .eoa_o(eoao_b), .grant_o(grant_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tx_a = '0; eop_a = '0; eoa_a = '0; data_a = '0; credit_a = 1'b1;
    tx_b = '0; eop_b = '0; eoa_b = '0; data_b = '0; credit_b = 1'b1;
    tick(); tick();
    chk("rst_tx", 64'(txo_a), 0);
    chk("rst_grant", 64'(grant_a), 0);
    chk("rst_data", 64'(datao_a), 0);
    chk("rst_credit", 64'(cred_a), 0);
    chk("rst_eoa", 64'(eoao_a), 0);
    chk("rst_grant_b", 64'(grant_b), 0);
    rst_n = 1'b1;

    // Single source, 3-flit packet
    tx_a = 2'b01; data_a[31:0] = 32'hA; #1;
    chk("t1_c0_grant", 64'(grant_a), 0);
    chk("t1_c0_tx", 64'(txo_a), 0);
    tick(); #1;
    chk("t1_c1_grant", 64'(grant_a), 2'b01);
    chk("t1_c1_data", 64'(datao_a), 32'hA);
    chk("t1_c1_credit", 64'(cred_a), 2'b01);
    tick(); data_a[31:0] = 32'hB; #1;
    chk("t1_c2_data", 64'(datao_a), 32'hB);
    tick(); data_a[31:0] = 32'hC; eop_a = 2'b01; #1;
    chk("t1_c3_data", 64'(datao_a), 32'hC);
    tick(); tx_a = 2'b00; eop_a = 2'b00; #1;
    chk("t1_c4_idle_grant", 64'(grant_a), 0);
    chk("t1_c4_idle_tx", 64'(txo_a), 0);
    tick();

    // Both sources request; rr_ptr=1 so source 1 wins first
    tx_a = 2'b11; data_a = {32'h200, 32'h100}; #1;
    chk("t2_idle0", 64'(grant_a), 0);
    tick(); #1;
    chk("t2_grant_s1", 64'(grant_a), 2'b10);
    chk("t2_data_s1a", 64'(datao_a), 32'h200);
    chk("t2_credit_s1", 64'(cred_a), 2'b10);
    tick(); data_a[63:32] = 32'h201; eop_a = 2'b10; #1;
    chk("t2_data_s1b", 64'(datao_a), 32'h201);
    tick(); data_a[63:32] = 32'h210; eop_a = 2'b00; #1;
    chk("t2_bubble1_grant", 64'(grant_a), 0);
    chk("t2_bubble1_tx", 64'(txo_a), 0);
    tick(); #1;
    chk("t2_grant_s0", 64'(grant_a), 2'b01);
    chk("t2_data_s0a", 64'(datao_a), 32'h100);
    tick(); data_a[31:0] = 32'h101; eop_a = 2'b01; #1;
    chk("t2_data_s0b", 64'(datao_a), 32'h101);
    tick(); eop_a = 2'b00; #1;
    chk("t2_bubble2_grant", 64'(grant_a), 0);
    tick(); #1;
    chk("t2_grant_s1_again", 64'(grant_a), 2'b10);
    chk("t2_data_s1c", 64'(datao_a), 32'h210);
    tick(); data_a[63:32] = 32'h211; eop_a = 2'b10; #1;
    chk("t2_data_s1d", 64'(datao_a), 32'h211);
    tick(); tx_a = 2'b00; eop_a = 2'b00;

    // Eop flit held with credit low (rr_ptr=0)
    tx_a = 2'b01; data_a[31:0] = 32'h300; eop_a = 2'b01; credit_a = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t3_hold_grant_%0d", i), 64'(grant_a), 2'b01);
      chk($sformatf("t3_hold_credit_%0d", i), 64'(cred_a), 2'b00);
      tick();
    end
    credit_a = 1'b1; #1;
    chk("t3_credit_up", 64'(cred_a), 2'b01);
    chk("t3_data", 64'(datao_a), 32'h300);
    tick(); tx_a = 2'b00; eop_a = 2'b00; #1;
    chk("t3_released", 64'(grant_a), 0);
    tick();

    // Owner stalls mid-packet while source 1 requests (rr_ptr=1, only source 0 asks first)
    tx_a = 2'b01; data_a[31:0] = 32'h400; eop_a = 2'b00;
    tick(); #1;
    chk("t4_grant_s0", 64'(grant_a), 2'b01);
    chk("t4_data0", 64'(datao_a), 32'h400);
    tick(); tx_a = 2'b10; data_a[63:32] = 32'h500;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("t4_stall_tx_%0d", i), 64'(txo_a), 0);
      chk($sformatf("t4_stall_grant_%0d", i), 64'(grant_a), 2'b01);
      tick();
    end
    tx_a = 2'b11; data_a[31:0] = 32'h401; eop_a = 2'b01; #1;
    chk("t4_data1", 64'(datao_a), 32'h401);
    tick(); tx_a = 2'b10; eop_a = 2'b00; #1;
    chk("t4_bubble", 64'(grant_a), 0);
    tick(); eop_a = 2'b10; #1;
    chk("t4_grant_s1", 64'(grant_a), 2'b10);
    chk("t4_data_s1", 64'(datao_a), 32'h500);
    tick(); tx_a = 2'b00; eop_a = 2'b00;

    // Single-flit packet from source 0 leaves rr_ptr=1
    tx_a = 2'b01; data_a[31:0] = 32'h4F0; eop_a = 2'b01;
    tick(); #1;
    chk("t5_single_data", 64'(datao_a), 32'h4F0);
    tick(); tx_a = 2'b00; eop_a = 2'b00;

    // Reset after flit 2 of 4
    tx_a = 2'b01; data_a[31:0] = 32'h600;
    tick(); #1;
    chk("t6_data0", 64'(datao_a), 32'h600);
    tick(); data_a[31:0] = 32'h601; #1;
    chk("t6_data1", 64'(datao_a), 32'h601);
    tick(); data_a[31:0] = 32'h602; rst_n = 1'b0; #1;
    chk("t6_rst_cycle_credit", 64'(cred_a), 0);
    chk("t6_rst_cycle_tx", 64'(txo_a), 0);
    tick(); rst_n = 1'b1; tx_a = 2'b11; data_a = {32'h700, 32'h603}; #1;
    chk("t6_after_tx", 64'(txo_a), 0);
    chk("t6_after_grant", 64'(grant_a), 0);
    chk("t6_after_data", 64'(datao_a), 0);
    chk("t6_after_credit", 64'(cred_a), 0);
    tick(); #1;
    chk("t6_rr_reset_grant", 64'(grant_a), 2'b01);
    tick(); tx_a = 2'b01; eop_a = 2'b01;
    tick(); tx_a = 2'b00; eop_a = 2'b00; eoa_a = 2'b11; #1;
    chk("t6_eoa_all", 64'(eoao_a), 1);
    eoa_a = 2'b01; #1;
    chk("t6_eoa_partial", 64'(eoao_a), 0);
    eoa_a = 2'b11; tx_a = 2'b10; #1;
    chk("t6_eoa_tx_idle", 64'(eoao_a), 0);
    tick(); tx_a = 2'b00; #1;
    chk("t6_eoa_busy", 64'(eoao_a), 0);
    tx_a = 2'b10; eop_a = 2'b10;
    tick(); tx_a = 2'b00; eop_a = 2'b00; #1;
    chk("t6_eoa_final", 64'(eoao_a), 1);

    // Three sources, single-flit packets, wrap-around order 0,1,2,0
    tx_b = 3'b111; eop_b = 3'b111; data_b = {32'hB2, 32'hB1, 32'hB0};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t7_idle_%0d", i), 64'(grant_b), 0);
      tick(); #1;
      chk($sformatf("t7_grant_%0d", i), 64'(grant_b), 64'(3'b001 << (i % 3)));
      chk($sformatf("t7_data_%0d", i), 64'(datao_b), 64'(32'hB0 + (i % 3)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
